// File: rtl/qam16_symbol_scheduler.sv
// QAM-16 transmit symbol scheduler.
// Buffers 4-bit symbols in a small FIFO, Gray-maps each one to signed I/Q
// levels and sequences the per-sample phase counter of the upsampler.
// Handles priming from IDLE, a graceful drain on stop, and zero-symbol
// insertion on FIFO underrun.
module qam16_symbol_scheduler #(
  parameter int SPS         = 11,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             sym_valid,
  input  logic [3:0]                       sym_data,
  output logic                             sym_ready,
  output logic [3:0]                       count,
  output logic [3:0]                       iout,
  output logic [3:0]                       qout,
  output logic                             sym_strobe,
  output logic                             underrun,
  output logic                             active,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fill_level
);

  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [3:0]    LAST_PHASE = 4'(SPS - 1);
  localparam logic [FW-1:0] FULL_LEVEL = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] PRIME      = FW'(PRIME_LEVEL);
  localparam logic [FW-1:0] ONE        = FW'(1);
  localparam logic [FW-1:0] ZERO       = FW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Gray mapping of one 2-bit field to a signed 4-bit level.
  function automatic logic [3:0] gray_level(input logic [1:0] bits);
    case (bits)
      2'b00:   gray_level = 4'b1101;  // -3
      2'b01:   gray_level = 4'b1111;  // -1
      2'b11:   gray_level = 4'b0001;  // +1
      default: gray_level = 4'b0011;  // +3 (2'b10)
    endcase
  endfunction

  state_t        state, state_next;
  logic [3:0]    count_next, iout_next, qout_next;
  logic          strobe_next, underrun_next;
  logic          boundary, push, pop, empty, last;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    head;

  assign empty     = (fill_level == ZERO);
  assign last      = (count == LAST_PHASE);
  assign head      = mem[rd_ptr];
  assign sym_ready = (fill_level < FULL_LEVEL) && (state != DRAIN);
  assign push      = sym_valid && sym_ready;

  // Next-state, phase counter and symbol-load decisions.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_next    = state;
    count_next    = count;
    iout_next     = iout;
    qout_next     = qout;
    strobe_next   = 1'b0;
    underrun_next = underrun;
    boundary      = 1'b0;
    pop           = 1'b0;

    case (state)
      IDLE: begin
        count_next = '0;
        iout_next  = '0;
        qout_next  = '0;
        if (enable && (fill_level >= PRIME)) begin
          state_next    = RUN;
          underrun_next = 1'b0;
          boundary      = 1'b1;
        end
      end
      RUN: begin
        if (last) begin
          boundary = 1'b1;
          if (!enable) begin
            state_next = empty ? IDLE : DRAIN;
          end else if (empty) begin
            underrun_next = 1'b1;
          end
        end else begin
          count_next = count + 4'd1;
        end
      end
      DRAIN: begin
        if (last) begin
          boundary = 1'b1;
          if (empty) state_next = IDLE;
        end else begin
          count_next = count + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        iout_next  = '0;
        qout_next  = '0;
      end
    endcase

    // A boundary restarts the phase and presents either the FIFO head or a zero symbol.
    if (boundary) begin
      count_next = '0;
      if (!empty) begin
        pop         = 1'b1;
        iout_next   = gray_level(head[3:2]);
        qout_next   = gray_level(head[1:0]);
        strobe_next = 1'b1;
      end else begin
        iout_next   = '0;
        qout_next   = '0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      iout       <= '0;
      qout       <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      iout       <= iout_next;
      qout       <= qout_next;
      sym_strobe <= strobe_next;
      underrun   <= underrun_next;
      active     <= (state_next != IDLE);
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fill_level <= fill_level + (push ? ONE : ZERO) - (pop ? ONE : ZERO);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy and pointers alone decide which entries are valid.
    if (push) mem[wr_ptr] <= sym_data;
  end

endmodule

// File: tb/tb_qam16_symbol_scheduler.sv
// Directed self-checking bench for qam16_symbol_scheduler (SPS=11, depth 4, prime 2).
module tb_qam16_symbol_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       sym_valid;
  logic [3:0] sym_data;
  logic       sym_ready;
  logic [3:0] count;
  logic [3:0] iout;
  logic [3:0] qout;
  logic       sym_strobe;
  logic       underrun;
  logic       active;
  logic [2:0] fill_level;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] M3 = 4'b1101;
  localparam logic [3:0] M1 = 4'b1111;
  localparam logic [3:0] P1 = 4'b0001;
  localparam logic [3:0] P3 = 4'b0011;

  qam16_symbol_scheduler #(
    .SPS(11),
    .FIFO_DEPTH(4),
    .PRIME_LEVEL(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sym_valid(sym_valid),
    .sym_data(sym_data),
    .sym_ready(sym_ready),
    .count(count),
    .iout(iout),
    .qout(qout),
    .sym_strobe(sym_strobe),
    .underrun(underrun),
    .active(active),
    .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] d);
    sym_valid = 1'b1;
    sym_data  = d;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    sym_valid = 1'b0;
    sym_data  = 4'h0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_count", 16'(count), 16'd0);
    check("rst_iout", 16'(iout), 16'd0);
    check("rst_qout", 16'(qout), 16'd0);
    check("rst_strobe", 16'(sym_strobe), 16'd0);
    check("rst_underrun", 16'(underrun), 16'd0);
    check("rst_active", 16'(active), 16'd0);
    check("rst_fill", 16'(fill_level), 16'd0);
    check("rst_ready", 16'(sym_ready), 16'd1);
  endtask

  initial begin
    logic [3:0] lv [3];
    lv[0] = M3;
    lv[1] = P1;
    lv[2] = P3;

    // Priming with three queued symbols, then steady symbol cadence.
    do_reset();
    push(4'h0);
    push(4'hF);
    push(4'hA);
    check("t1_fill_idle", 16'(fill_level), 16'd3);
    check("t1_active_idle", 16'(active), 16'd0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 33; i++) begin
      check("t1_count", 16'(count), 16'(i % 11));
      check("t1_strobe", 16'(sym_strobe), 16'((i % 11) == 0));
      check("t1_iout", 16'(iout), 16'(lv[i / 11]));
      check("t1_qout", 16'(qout), 16'(lv[i / 11]));
      tick();
    end

    // Underrun: empty FIFO at the boundary inserts a zero symbol.
    check("t3_count", 16'(count), 16'd0);
    check("t3_iout_zero", 16'(iout), 16'd0);
    check("t3_qout_zero", 16'(qout), 16'd0);
    check("t3_strobe", 16'(sym_strobe), 16'd0);
    check("t3_underrun", 16'(underrun), 16'd1);
    check("t3_active", 16'(active), 16'd1);
    push(4'h6);
    check("t3_fill", 16'(fill_level), 16'd1);
    check("t3_underrun_sticky", 16'(underrun), 16'd1);
    check("t3_count1", 16'(count), 16'd1);
    repeat (10) tick();
    check("t3_resume_count", 16'(count), 16'd0);
    check("t3_resume_iout", 16'(iout), 16'(M1));
    check("t3_resume_qout", 16'(qout), 16'(P3));
    check("t3_resume_strobe", 16'(sym_strobe), 16'd1);
    check("t3_resume_underrun", 16'(underrun), 16'd1);
    check("t3_resume_fill", 16'(fill_level), 16'd0);

    // One symbol is below the priming level; the second primes.
    do_reset();
    enable = 1'b1;
    push(4'h5);
    check("t2_active_one", 16'(active), 16'd0);
    check("t2_count_one", 16'(count), 16'd0);
    check("t2_fill_one", 16'(fill_level), 16'd1);
    push(4'h5);
    check("t2_active_two", 16'(active), 16'd0);
    check("t2_fill_two", 16'(fill_level), 16'd2);
    tick();
    check("t2_active_run", 16'(active), 16'd1);
    check("t2_count_run", 16'(count), 16'd0);
    check("t2_iout", 16'(iout), 16'(M1));
    check("t2_qout", 16'(qout), 16'(M1));
    check("t2_strobe", 16'(sym_strobe), 16'd1);
    check("t2_fill_run", 16'(fill_level), 16'd1);

    // Full FIFO refuses a held symbol; the priming pop reopens it.
    do_reset();
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    check("t4_fill_full", 16'(fill_level), 16'd4);
    check("t4_ready_full", 16'(sym_ready), 16'd0);
    sym_valid = 1'b1;
    sym_data  = 4'h7;
    tick();
    check("t4_fill_held", 16'(fill_level), 16'd4);
    enable = 1'b1;
    tick();
    check("t4_fill_pop", 16'(fill_level), 16'd3);
    check("t4_ready_pop", 16'(sym_ready), 16'd1);
    check("t4_iout", 16'(iout), 16'(M3));
    check("t4_qout", 16'(qout), 16'(M1));
    check("t4_strobe", 16'(sym_strobe), 16'd1);
    sym_valid = 1'b0;

    // Drop enable mid-symbol with three queued, then drain to IDLE.
    repeat (4) tick();
    check("t5_count4", 16'(count), 16'd4);
    enable = 1'b0;
    repeat (6) tick();
    check("t5_count10", 16'(count), 16'd10);
    check("t5_active_mid", 16'(active), 16'd1);
    check("t5_iout_hold", 16'(iout), 16'(M3));
    tick();
    check("t5_d1_iout", 16'(iout), 16'(M3));
    check("t5_d1_qout", 16'(qout), 16'(P3));
    check("t5_d1_strobe", 16'(sym_strobe), 16'd1);
    check("t5_d1_fill", 16'(fill_level), 16'd2);
    check("t5_d1_ready", 16'(sym_ready), 16'd0);
    sym_valid = 1'b1;
    sym_data  = 4'h9;
    enable    = 1'b1;
    tick();
    check("t5_no_push", 16'(fill_level), 16'd2);
    check("t5_d1_count1", 16'(count), 16'd1);
    sym_valid = 1'b0;
    repeat (10) tick();
    check("t5_d2_iout", 16'(iout), 16'(M3));
    check("t5_d2_qout", 16'(qout), 16'(P1));
    check("t5_d2_strobe", 16'(sym_strobe), 16'd1);
    check("t5_d2_fill", 16'(fill_level), 16'd1);
    check("t5_d2_ready", 16'(sym_ready), 16'd0);
    enable = 1'b0;
    repeat (11) tick();
    check("t5_d3_iout", 16'(iout), 16'(M1));
    check("t5_d3_qout", 16'(qout), 16'(M3));
    check("t5_d3_fill", 16'(fill_level), 16'd0);
    check("t5_d3_active", 16'(active), 16'd1);
    repeat (11) tick();
    check("t5_idle_active", 16'(active), 16'd0);
    check("t5_idle_count", 16'(count), 16'd0);
    check("t5_idle_iout", 16'(iout), 16'd0);
    check("t5_idle_qout", 16'(qout), 16'd0);
    check("t5_idle_strobe", 16'(sym_strobe), 16'd0);
    check("t5_idle_underrun", 16'(underrun), 16'd0);
    check("t5_idle_ready", 16'(sym_ready), 16'd1);

    // Reset mid-symbol discards the queue and the in-flight symbol.
    do_reset();
    push(4'h0);
    push(4'hF);
    push(4'hA);
    enable = 1'b1;
    tick();
    check("t6_fill_run", 16'(fill_level), 16'd2);
    repeat (6) tick();
    check("t6_count6", 16'(count), 16'd6);
    check("t6_iout_run", 16'(iout), 16'(M3));
    reset = 1'b1;
    tick();
    check("t6_count", 16'(count), 16'd0);
    check("t6_iout", 16'(iout), 16'd0);
    check("t6_qout", 16'(qout), 16'd0);
    check("t6_strobe", 16'(sym_strobe), 16'd0);
    check("t6_underrun", 16'(underrun), 16'd0);
    check("t6_active", 16'(active), 16'd0);
    check("t6_fill", 16'(fill_level), 16'd0);
    check("t6_ready", 16'(sym_ready), 16'd1);
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    check("t6_after_active", 16'(active), 16'd0);
    check("t6_after_fill", 16'(fill_level), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
